// File: rtl/instruction_fetch_stage_if.sv
// Bus between the fetch stage, the instruction memory and the decode stage.
// The Fetch_Misalign signal exists only when FETCH_MISALIGN_CHECK_EN is defined.
interface instruction_fetch_stage_if #(
  parameter int PC_WIDTH = 64
);
  logic                Stall;
  logic                Branch_Taken;
  logic [PC_WIDTH-1:0] Branch_Target;
  logic [PC_WIDTH-1:0] Inst_Address;
  logic [31:0]         Instruction;
  logic [PC_WIDTH-1:0] IFID_PC;
  logic [31:0]         IFID_Inst;
  logic                IFID_Valid;
  logic                Halted;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                Fetch_Misalign;
`endif

  // Fetch-stage side
  modport master (
    input  Stall, Branch_Taken, Branch_Target, Instruction,
    output Inst_Address, IFID_PC, IFID_Inst, IFID_Valid, Halted
`ifdef FETCH_MISALIGN_CHECK_EN
    , output Fetch_Misalign
`endif
  );

  // Environment side: memory, decode and execute
  modport slave (
    output Stall, Branch_Taken, Branch_Target, Instruction,
    input  Inst_Address, IFID_PC, IFID_Inst, IFID_Valid, Halted
`ifdef FETCH_MISALIGN_CHECK_EN
    , input Fetch_Misalign
`endif
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address,
// and captures the returned instruction into the IF/ID pipeline register.
// It honours the decode stall and the execute branch redirect, and parks in
// HALT once the PC runs past the loaded program.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When it is defined,
// misaligned branch targets are force-aligned and flagged on Fetch_Misalign.
module instruction_fetch_stage #(
  parameter int                  PC_WIDTH  = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  MEM_BYTES = 144
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_stage_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [PC_WIDTH-1:0] MEM_LIMIT = PC_WIDTH'(MEM_BYTES);
  localparam logic [31:0]         NOP_INST  = 32'h0000_0013;

  // Redirect address actually loaded into the PC
  function automatic logic [PC_WIDTH-1:0] redirect_pc(input logic [PC_WIDTH-1:0] target);
`ifdef FETCH_MISALIGN_CHECK_EN
    return {target[PC_WIDTH-1:2], 2'b00};
`else
    return target;
`endif
  endfunction

  state_t              state_p0;
  logic [PC_WIDTH-1:0] pc_p0;
  logic [PC_WIDTH-1:0] ifid_pc_p1;
  logic [31:0]         ifid_inst_p1;
  logic                vld_p1;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] tgt_pc;
  logic                tgt_out;

  assign pc_inc  = pc_p0 + PC_WIDTH'(4);
  assign tgt_pc  = redirect_pc(bus.Branch_Target);
  assign tgt_out = (bus.Branch_Target >= MEM_LIMIT);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_p1;
  logic misalign_req;

  assign misalign_req       = |bus.Branch_Target[1:0];
  assign bus.Fetch_Misalign = misalign_p1;
`endif

  // Fetch FSM: PC, IF/ID register and halt tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0     <= BOOT;
      pc_p0        <= RESET_PC;
      ifid_pc_p1   <= '0;
      ifid_inst_p1 <= NOP_INST;
      vld_p1       <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_p1  <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_p1 <= 1'b0;
`endif
      case (state_p0)
        BOOT: begin
          vld_p1   <= 1'b0;
          state_p0 <= RUN;
        end
        RUN: begin
          if (bus.Branch_Taken) begin
            // Redirect squashes the wrong-path fetch and beats Stall
            pc_p0    <= tgt_pc;
            vld_p1   <= 1'b0;
            state_p0 <= tgt_out ? HALT : RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_p1 <= misalign_req;
`endif
          end else if (!bus.Stall) begin
            ifid_pc_p1   <= pc_p0;
            ifid_inst_p1 <= bus.Instruction;
            vld_p1       <= 1'b1;
            pc_p0        <= pc_inc;
            if (pc_inc >= MEM_LIMIT) state_p0 <= HALT;
          end
        end
        HALT: begin
          if (bus.Branch_Taken) begin
            // A redirect always reloads the PC; it resumes only when in range
            pc_p0    <= tgt_pc;
            vld_p1   <= 1'b0;
            state_p0 <= tgt_out ? HALT : RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_p1 <= misalign_req;
`endif
          end else if (!bus.Stall) begin
            vld_p1 <= 1'b0;
          end
        end
        default: state_p0 <= BOOT;
      endcase
    end
  end

  assign bus.Inst_Address = pc_p0;
  assign bus.IFID_PC      = ifid_pc_p1;
  assign bus.IFID_Inst    = ifid_inst_p1;
  assign bus.IFID_Valid   = vld_p1;
  assign bus.Halted       = (state_p0 == HALT);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational memory model.
module tb_instruction_fetch_stage;
  localparam int PC_WIDTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instruction_fetch_stage_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  instruction_fetch_stage #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC ('0),
    .MEM_BYTES(144)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // 144-byte program: two known words, then 0xA0000000 | word index
  function automatic logic [31:0] mem_word(input logic [PC_WIDTH-1:0] a);
    logic [PC_WIDTH-1:0] idx;
    idx = a >> 2;
    if (a >= 64'd144) return 32'h0000_0013;
    if (idx == 0) return 32'h0000_0913;
    if (idx == 1) return 32'h0050_0993;
    return 32'hA000_0000 | 32'(idx);
  endfunction

  assign bus.Instruction = mem_word(bus.Inst_Address);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.Stall = 1'b0; bus.Branch_Taken = 1'b0; bus.Branch_Target = '0;
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.Inst_Address !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", bus.Inst_Address); end
    checks++; if (bus.IFID_PC !== 64'h0) begin errors++; $display("FAIL rst_ifid_pc: got %h want 0", bus.IFID_PC); end
    checks++; if (bus.IFID_Inst !== 32'h13) begin errors++; $display("FAIL rst_inst: got %h want 00000013", bus.IFID_Inst); end
    checks++; if (bus.IFID_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.IFID_Valid); end
    checks++; if (bus.Halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", bus.Halted); end
    reset = 1'b1;
    step();
    checks++; if (bus.IFID_Valid !== 1'b0 || bus.Inst_Address !== 64'h0) begin errors++; $display("FAIL boot: valid %b addr %h want 0 0", bus.IFID_Valid, bus.Inst_Address); end
  endtask

  task automatic test_straight_line();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.IFID_PC !== 64'(4*k) || bus.IFID_Valid !== 1'b1) begin errors++; $display("FAIL line_pc[%0d]: got %h/%b want %h/1", k, bus.IFID_PC, bus.IFID_Valid, 4*k); end
      if (k == 0) begin checks++; if (bus.IFID_Inst !== 32'h0000_0913) begin errors++; $display("FAIL line_inst0: got %h want 00000913", bus.IFID_Inst); end end
      if (k == 1) begin checks++; if (bus.IFID_Inst !== 32'h0050_0993) begin errors++; $display("FAIL line_inst1: got %h want 00500993", bus.IFID_Inst); end end
    end
    checks++; if (bus.Inst_Address !== 64'h10) begin errors++; $display("FAIL line_addr: got %h want 10", bus.Inst_Address); end
  endtask

  task automatic test_stall();
    bus.Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.Inst_Address !== 64'h10 || bus.IFID_PC !== 64'h0C || bus.IFID_Valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: addr %h pc %h v %b want 10 0c 1", k, bus.Inst_Address, bus.IFID_PC, bus.IFID_Valid); end
    end
    bus.Stall = 1'b0;
    step();
    checks++; if (bus.IFID_PC !== 64'h10 || bus.IFID_Inst !== 32'hA000_0004 || bus.Inst_Address !== 64'h14) begin errors++; $display("FAIL stall_resume: pc %h inst %h addr %h want 10 a0000004 14", bus.IFID_PC, bus.IFID_Inst, bus.Inst_Address); end
    // Advance to PC = 0x40
    for (int k = 0; k < 11; k++) step();
    checks++; if (bus.Inst_Address !== 64'h40 || bus.IFID_PC !== 64'h3C) begin errors++; $display("FAIL run_to_40: addr %h pc %h want 40 3c", bus.Inst_Address, bus.IFID_PC); end
  endtask

  task automatic test_redirect();
    bus.Stall = 1'b1; bus.Branch_Taken = 1'b1; bus.Branch_Target = 64'h28;
    step();
    bus.Stall = 1'b0; bus.Branch_Taken = 1'b0;
    checks++; if (bus.Inst_Address !== 64'h28 || bus.IFID_Valid !== 1'b0) begin errors++; $display("FAIL redir_bubble: addr %h v %b want 28 0", bus.Inst_Address, bus.IFID_Valid); end
    step();
    checks++; if (bus.IFID_PC !== 64'h28 || bus.IFID_Valid !== 1'b1 || bus.IFID_Inst !== 32'hA000_000A) begin errors++; $display("FAIL redir_fetch: pc %h v %b inst %h want 28 1 a000000a", bus.IFID_PC, bus.IFID_Valid, bus.IFID_Inst); end
  endtask

  task automatic test_halt();
    // From PC 0x2C, 25 edges fetch up to and including 0x8C
    for (int k = 0; k < 25; k++) begin
      step();
      checks++; if (bus.IFID_PC !== 64'(32'h2C + 4*k)) begin errors++; $display("FAIL halt_walk[%0d]: got %h want %h", k, bus.IFID_PC, 32'h2C + 4*k); end
    end
    checks++; if (bus.Halted !== 1'b1 || bus.IFID_Valid !== 1'b1 || bus.Inst_Address !== 64'h90) begin errors++; $display("FAIL halt_enter: h %b v %b addr %h want 1 1 90", bus.Halted, bus.IFID_Valid, bus.Inst_Address); end
    step();
    checks++; if (bus.Halted !== 1'b1 || bus.IFID_Valid !== 1'b0 || bus.Inst_Address !== 64'h90) begin errors++; $display("FAIL halt_park: h %b v %b addr %h want 1 0 90", bus.Halted, bus.IFID_Valid, bus.Inst_Address); end
    bus.Branch_Taken = 1'b1; bus.Branch_Target = 64'h84;
    step();
    bus.Branch_Taken = 1'b0;
    checks++; if (bus.Halted !== 1'b0 || bus.Inst_Address !== 64'h84 || bus.IFID_Valid !== 1'b0) begin errors++; $display("FAIL halt_exit: h %b addr %h v %b want 0 84 0", bus.Halted, bus.Inst_Address, bus.IFID_Valid); end
    step();
    checks++; if (bus.IFID_PC !== 64'h84 || bus.IFID_Valid !== 1'b1 || bus.Halted !== 1'b0) begin errors++; $display("FAIL halt_refetch: pc %h v %b h %b want 84 1 0", bus.IFID_PC, bus.IFID_Valid, bus.Halted); end
    bus.Branch_Taken = 1'b1; bus.Branch_Target = 64'h200;
    step();
    checks++; if (bus.Halted !== 1'b1 || bus.Inst_Address !== 64'h200 || bus.IFID_Valid !== 1'b0) begin errors++; $display("FAIL halt_far: h %b addr %h v %b want 1 200 0", bus.Halted, bus.Inst_Address, bus.IFID_Valid); end
    bus.Branch_Target = 64'h90;
    step();
    bus.Branch_Taken = 1'b0;
    checks++; if (bus.Halted !== 1'b1 || bus.Inst_Address !== 64'h90) begin errors++; $display("FAIL halt_edge: h %b addr %h want 1 90", bus.Halted, bus.Inst_Address); end
  endtask

  task automatic test_misalign();
    bus.Branch_Taken = 1'b1; bus.Branch_Target = 64'h2A;
    step();
    bus.Branch_Taken = 1'b0;
    checks++; if (bus.Halted !== 1'b0) begin errors++; $display("FAIL mis_run: h %b want 0", bus.Halted); end
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if (bus.Inst_Address !== 64'h28 || bus.Fetch_Misalign !== 1'b1) begin errors++; $display("FAIL mis_align: addr %h flag %b want 28 1", bus.Inst_Address, bus.Fetch_Misalign); end
    step();
    checks++; if (bus.Fetch_Misalign !== 1'b0 || bus.IFID_PC !== 64'h28) begin errors++; $display("FAIL mis_pulse: flag %b pc %h want 0 28", bus.Fetch_Misalign, bus.IFID_PC); end
`else
    checks++; if (bus.Inst_Address !== 64'h2A) begin errors++; $display("FAIL mis_raw: addr %h want 2a", bus.Inst_Address); end
    step();
    checks++; if (bus.IFID_PC !== 64'h2A || bus.IFID_Valid !== 1'b1) begin errors++; $display("FAIL mis_raw_fetch: pc %h v %b want 2a 1", bus.IFID_PC, bus.IFID_Valid); end
`endif
  endtask

  task automatic test_async_reset();
    step();
    @(posedge clk); #3;
    bus.Stall = 1'b1; bus.Branch_Taken = 1'b1; bus.Branch_Target = 64'h60;
    reset = 1'b0;
    #1;
    checks++; if (bus.Inst_Address !== 64'h0 || bus.IFID_PC !== 64'h0 || bus.IFID_Inst !== 32'h13 || bus.IFID_Valid !== 1'b0 || bus.Halted !== 1'b0) begin errors++; $display("FAIL async_rst: addr %h pc %h inst %h v %b h %b", bus.Inst_Address, bus.IFID_PC, bus.IFID_Inst, bus.IFID_Valid, bus.Halted); end
    step();
    bus.Stall = 1'b0; bus.Branch_Taken = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (bus.IFID_Valid !== 1'b0 || bus.Inst_Address !== 64'h0) begin errors++; $display("FAIL async_boot: v %b addr %h want 0 0", bus.IFID_Valid, bus.Inst_Address); end
    step();
    checks++; if (bus.IFID_PC !== 64'h0 || bus.IFID_Valid !== 1'b1 || bus.Inst_Address !== 64'h4) begin errors++; $display("FAIL async_restart: pc %h v %b addr %h want 0 1 4", bus.IFID_PC, bus.IFID_Valid, bus.Inst_Address); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_straight_line();
    test_stall();
    test_redirect();
    test_halt();
    test_misalign();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
